// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int              DEF_ADDR_W   = 12;
  localparam int              DEF_INSTR_W  = 16;
  localparam int              DEF_DEPTH    = 2;
  localparam logic [11:0]     DEF_RESET_PC = 12'h000;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small shift-register FIFO: the head always sits in entry 0 so the outputs
// come straight from a register.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = DEF_DEPTH,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  entry_t                        push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output entry_t                        head
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;

  // A simultaneous pop shifts everything down, so the new tail lands one lower.
  assign wr_idx = IDX_W'(count - CNT_W'(pop));
  assign head   = mem[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      // NOTE: the entries are reset because the head drives out_instr/out_pc,
      // which must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      // NOTE: non-blocking here, so the push below overrides the shift of
      // the same slot while the other slots still see pre-edge values.
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (push) mem[wr_idx] <= push_data;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// PC / fetch stage in front of a 1-cycle synchronous instruction memory,
// buffering responses in a small queue that decode drains via valid/ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = DEF_ADDR_W,
  parameter int                 INSTR_W  = DEF_INSTR_W,
  parameter int                 DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  localparam int CNT_W = cnt_width(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              pop;
  logic              push;
  logic              issue;
  entry_t            push_data;
  entry_t            head;

  // In-flight fetches reserve a slot so the queue can never overflow.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight);
  assign pop       = out_valid && out_ready;
  assign issue     = fetch_en && !branch_valid &&
                     ((occupancy < (CNT_W+1)'(DEPTH)) || pop);
  assign push      = inflight && !branch_valid;
  assign push_data = '{instr: imem_instr, pc: inflight_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (branch_valid) begin
      pc          <= branch_target;
      inflight    <= 1'b0;
    end else if (issue) begin
      pc          <= pc + 1'b1;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (branch_valid),
    .count     (count),
    .head      (head)
  );

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule
